// File: rtl/entrada_dados_bcd.sv
// Keypad decimal-entry block: accumulates BCD digits into a binary word with a valid/ready handoff.
// Optional signed entry (sinal port, negativo flag) is enabled by defining ENTRADA_SINAL_EN.
module entrada_dados_bcd #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIGITS = 5,
  localparam int NW = $clog2(MAX_DIGITS + 1),
  localparam int EW = 4 * MAX_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            digito,
  input  logic                  digito_valido,
  input  logic                  confirma,
  input  logic                  limpa,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [EW-1:0]         eco_bcd,
  output logic [NW-1:0]         num_digitos,
  output logic                  ocupado,
`ifdef ENTRADA_SINAL_EN
  input  logic                  sinal,
  output logic                  negativo,
`endif
  output logic                  erro
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ENTRADA = 2'd1,
    PRONTO  = 2'd2
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [EW-1:0]         eco_q, eco_d;
  logic [NW-1:0]         num_q, num_d;
  logic                  data_valid_q, data_valid_d;
  logic                  ocupado_q, ocupado_d;
  logic                  erro_q, erro_d;
  logic [DATA_WIDTH+3:0] cand_s, limite_s, acc_ext_s;
`ifdef ENTRADA_SINAL_EN
  logic                  neg_q, neg_d;
  logic [DATA_WIDTH+3:0] limite_pos_s, limite_neg_s;
`endif

  // Candidate acc*10 + digit computed wide enough that overflow is visible.
  always_comb begin
    acc_ext_s = {4'b0000, acc_q};
    cand_s    = (acc_ext_s << 3) + (acc_ext_s << 1) + {{DATA_WIDTH{1'b0}}, digito};
`ifdef ENTRADA_SINAL_EN
    limite_pos_s = {5'b00000, {(DATA_WIDTH-1){1'b1}}};
    limite_neg_s = limite_pos_s + {{(DATA_WIDTH+3){1'b0}}, 1'b1};
    limite_s     = neg_q ? limite_neg_s : limite_pos_s;
`else
    limite_s = {4'b0000, {DATA_WIDTH{1'b1}}};
`endif
  end

  // Next-state logic; priority is limpa > PRONTO handling > confirma > sinal > digit.
  always_comb begin
    estado_d = estado_q;
    acc_d    = acc_q;
    data_d   = data_q;
    eco_d    = eco_q;
    num_d    = num_q;
    erro_d   = 1'b0;
`ifdef ENTRADA_SINAL_EN
    neg_d    = neg_q;
`endif
    if (limpa) begin
      estado_d = OCIOSO;
      acc_d    = {DATA_WIDTH{1'b0}};
      eco_d    = {EW{1'b0}};
      num_d    = {NW{1'b0}};
`ifdef ENTRADA_SINAL_EN
      neg_d    = 1'b0;
`endif
    end else if (estado_q == PRONTO) begin
      erro_d = confirma | digito_valido;
      if (data_ready) begin
        estado_d = OCIOSO;
        acc_d    = {DATA_WIDTH{1'b0}};
        eco_d    = {EW{1'b0}};
        num_d    = {NW{1'b0}};
`ifdef ENTRADA_SINAL_EN
        neg_d    = 1'b0;
`endif
      end else begin
        estado_d = PRONTO;
      end
    end else if (confirma) begin
      if (estado_q == ENTRADA) begin
        estado_d = PRONTO;
`ifdef ENTRADA_SINAL_EN
        data_d   = neg_q ? (~acc_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : acc_q;
`else
        data_d   = acc_q;
`endif
      end else begin
        estado_d = estado_q;
      end
`ifdef ENTRADA_SINAL_EN
    end else if (sinal) begin
      // The limit that applies after the toggle is the one for the opposite sign.
      if (acc_ext_s > (neg_q ? limite_pos_s : limite_neg_s)) begin
        erro_d = 1'b1;
      end else begin
        neg_d = ~neg_q;
      end
`endif
    end else if (digito_valido) begin
      if ((digito > 4'd9) || (num_q == NW'(MAX_DIGITS)) || (cand_s > limite_s)) begin
        erro_d = 1'b1;
      end else begin
        acc_d    = cand_s[DATA_WIDTH-1:0];
        eco_d    = {eco_q[EW-5:0], digito};
        num_d    = num_q + {{(NW-1){1'b0}}, 1'b1};
        estado_d = ENTRADA;
      end
    end else begin
      estado_d = estado_q;
    end
    data_valid_d = (estado_d == PRONTO);
    ocupado_d    = (estado_d != OCIOSO);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      acc_q        <= {DATA_WIDTH{1'b0}};
      data_q       <= {DATA_WIDTH{1'b0}};
      eco_q        <= {EW{1'b0}};
      num_q        <= {NW{1'b0}};
      data_valid_q <= 1'b0;
      ocupado_q    <= 1'b0;
      erro_q       <= 1'b0;
`ifdef ENTRADA_SINAL_EN
      neg_q        <= 1'b0;
`endif
    end else begin
      estado_q     <= estado_d;
      acc_q        <= acc_d;
      data_q       <= data_d;
      eco_q        <= eco_d;
      num_q        <= num_d;
      data_valid_q <= data_valid_d;
      ocupado_q    <= ocupado_d;
      erro_q       <= erro_d;
`ifdef ENTRADA_SINAL_EN
      neg_q        <= neg_d;
`endif
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign eco_bcd     = eco_q;
  assign num_digitos = num_q;
  assign ocupado     = ocupado_q;
  assign erro        = erro_q;
`ifdef ENTRADA_SINAL_EN
  assign negativo    = neg_q;
`endif

endmodule

// File: doc/entrada_dados_bcd.md
Name: entrada_dados_bcd

Overview:
- Input-side counterpart of the binary-to-7-segment output path.
- Accepts decimal digits one at a time from a debounced keypad and accumulates them into a DATA_WIDTH-bit binary word (acc = acc*10 + digit).
- Presents the word to the processor core with a valid/ready handshake.
- Exposes an echo of the typed digits in BCD so the existing display path can show entry in progress.

Parameters:
- DATA_WIDTH, 16, width of the produced binary word.
- MAX_DIGITS, 5, maximum number of decimal digits accepted per entry; echo width is 4*MAX_DIGITS.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- digito  input  4  BCD digit from the keypad; sampled only when digito_valido=1.
- digito_valido  input  1  one-cycle pulse, a key was pressed.
- confirma  input  1  one-cycle pulse, ENTER key.
- limpa  input  1  one-cycle pulse, CLEAR key.
- data  output  DATA_WIDTH  accumulated binary value.
- data_valid  output  1  data holds a confirmed value.
- data_ready  input  1  consumer accepts data.
- eco_bcd  output  4*MAX_DIGITS  typed digits, right-aligned; the newest digit is in bits [3:0].
- num_digitos  output  $clog2(MAX_DIGITS+1)  digits accepted so far.
- ocupado  output  1  1 when state != OCIOSO.
- erro  output  1  one-cycle pulse on a rejected key.

Behaviour:
- Reset (synchronous, active-high): state=OCIOSO; acc, data, eco_bcd and num_digitos = 0; data_valid, erro and ocupado = 0.
- States:
  - OCIOSO: no digits.
  - ENTRADA: at least 1 digit accepted.
  - PRONTO: data_valid=1, waiting for data_ready.
- Event priority in the same cycle: reset > limpa > confirma > digito_valido. A digit pulse coincident with confirma or limpa is dropped silently, with no erro pulse.
- limpa (any state except under reset):
  - Next state OCIOSO.
  - acc, eco_bcd and num_digitos cleared.
  - data_valid deasserted next cycle; a pending value is discarded.
- digito_valido in OCIOSO or ENTRADA:
  - digito > 9: ignored, erro=1 next cycle.
  - num_digitos == MAX_DIGITS: ignored, erro=1.
  - Otherwise compute cand = (acc<<3) + (acc<<1) + digito in DATA_WIDTH+4 bits.
    - cand > 2^DATA_WIDTH-1: ignored, erro=1, acc unchanged.
    - Else acc <= cand, eco_bcd <= {eco_bcd[4*MAX_DIGITS-5:0], digito}, num_digitos += 1, state=ENTRADA.
  - One digit per cycle; back-to-back pulses on consecutive cycles must all be accepted.
  - Leading zeros count as digits: "0","0","7" gives acc=7, num_digitos=3.
- confirma:
  - In OCIOSO: ignored, no erro.
  - In ENTRADA: data <= acc, data_valid=1 on the next cycle (latency 1), state=PRONTO.
- In PRONTO:
  - digito_valido and confirma are ignored with erro=1.
  - data and eco_bcd are held stable.
  - When data_valid && data_ready are both 1 in a cycle, the next cycle has state=OCIOSO, data_valid=0, acc/eco_bcd/num_digitos=0. data keeps its last value.
- data_ready outside PRONTO has no effect.
- ocupado is registered: 1 in ENTRADA and PRONTO.

Optional Feature:
- Macro: ENTRADA_SINAL_EN.
- Defined:
  - Adds input port sinal (1 bit, one-cycle pulse) and output negativo (1 bit).
  - sinal in OCIOSO or ENTRADA toggles negativo. The toggle is rejected with erro=1 if acc exceeds the new limit.
  - Magnitude limit: 2^(DATA_WIDTH-1)-1 when positive, 2^(DATA_WIDTH-1) when negative.
  - On confirma, data = negativo ? -acc : acc, in two's complement.
  - negativo is cleared by reset, limpa, and handshake completion.
  - Priority: sinal sits below confirma and above digito_valido; a coincident digit is dropped.
- Undefined: no sinal or negativo ports; data is unsigned with limit 2^DATA_WIDTH-1.

Test Plan:
- Digits 1,2,3,4,5 on consecutive cycles, then confirma, with data_ready held 0 → data=12345 (0x3039), data_valid=1 one cycle after confirma, eco_bcd=0x12345; raise data_ready → next cycle data_valid=0, eco_bcd=0, ocupado=0.
- Digits 6,5,5,3,6 → digit 6 rejected with erro pulse, acc=6553, num_digitos=4; digit 5 → acc=65535; any further digit → erro=1, num_digitos=5 unchanged.
- digito=0xA pulse → erro=1, num_digitos stays 0, state stays OCIOSO; confirma in OCIOSO → no data_valid, no erro.
- Digits 4,2, then limpa and digito_valido with 9 on the same cycle → acc=0, eco_bcd=0, state OCIOSO, no erro; confirma plus a digit in the same cycle after "7" → data=7, digit dropped.
- In PRONTO with data=7, send digit 3 → erro=1, data stays 7; assert reset while in PRONTO → next cycle all outputs 0.
- (ENTRADA_SINAL_EN) sinal, then 3,2,7,6,8, confirma → data=0x8000, negativo=1; repeat with sinal pulsed again after the digits → toggle rejected, erro=1, negativo stays 1.
